spi_frame_ctrl: RTL and testbench

Parametrised multi-byte SPI frame sequencer. Sits between a user block (joystick/sensor poller, game logic) and the existing single-byte SPI mode-0 shifter. Owns CS framing, per-byte handshake with the shifter, configurable CS setup and inter-byte gap, and assembles an N-byte receive frame. Each start pulse runs one transaction.

---
 rtl/spi_frame_pkg.sv | 25 ++
 rtl/spi_frame_delay.sv | 32 +++
 rtl/spi_frame_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame sequencer.
//   state_e     : frame sequencer states
//   BYTE_W      : width of one SPI byte
//   delay_load  : converts a cycle count into a down-counter load value
package spi_frame_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned MAX_NUM_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    REQ     = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    GAP     = 3'd5,
    DONE    = 3'd6
  } state_e;

  // A delay of N cycles occupies max(N,1) cycles; the counter runs from N-1 to 0.
  function automatic logic [BYTE_W-1:0] delay_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : BYTE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_frame_delay.sv
// Loadable 8-bit down-counter with zero flag, shared by CS setup and byte gap.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement while non-zero
//   o_zero_c    : counter is zero (combinational)
module spi_frame_delay
  import spi_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero_c
);

  logic [BYTE_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin : p_cnt
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - BYTE_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/spi_frame_ctrl.sv
// Multi-byte SPI frame sequencer in front of a single-byte mode-0 shifter.
// Owns CS framing, per-byte get_byte/shifter_busy handshake, CS setup and
// inter-byte gap delays, and assembles an N-byte receive frame.
// Optional macro SPI_FRAME_TIMEOUT_EN enables a REQ/WAIT watchdog.
//   clk, rst_n    : clock, async active-low reset
//   start         : one-cycle request, honoured only in IDLE
//   tx_frame      : bytes to send, MSB byte first, latched on accepted start
//   busy, done    : transaction in progress / one-cycle completion pulse
//   rx_frame      : last complete received frame, first byte in MSB
//   cs_n          : SPI chip select, active low
//   get_byte      : request to shifter, data_send valid while high
//   shifter_busy  : shifter transfer in progress
//   data_rx       : received byte, valid when shifter_busy falls
//   timeout_err   : sticky watchdog flag (0 when the watchdog is not built)
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 5,
  parameter int unsigned CS_SETUP       = 2,
  parameter int unsigned BYTE_GAP       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BYTE_W*NUM_BYTES-1:0] tx_frame,
  output logic                        busy,
  output logic                        done,
  output logic [BYTE_W*NUM_BYTES-1:0] rx_frame,
  output logic                        cs_n,
  output logic                        get_byte,
  output logic [BYTE_W-1:0]           data_send,
  input  logic                        shifter_busy,
  input  logic [BYTE_W-1:0]           data_rx,
  output logic                        timeout_err
);

  localparam int unsigned FRAME_W = BYTE_W * NUM_BYTES;
  localparam int unsigned CNT_W   = $clog2(NUM_BYTES + 1);
  localparam logic [BYTE_W-1:0] SETUP_LD = delay_load(CS_SETUP);
  localparam logic [BYTE_W-1:0] GAP_LD   = delay_load(BYTE_GAP);

  // Elaboration-time guard on parameter ranges.
  if (NUM_BYTES < 1 || NUM_BYTES > MAX_NUM_BYTES || CS_SETUP > 255 ||
      BYTE_GAP > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_frame_ctrl: parameter out of legal range");
  end

  state_e             r_state;
  state_e             w_state_next;
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_shift_next;
  logic [FRAME_W-1:0] r_rx_frame;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [BYTE_W-1:0]  r_data_send;
  logic               r_cs_n;
  logic               r_busy;
  logic               r_done;
  logic               r_get_byte;
  logic               w_dly_load;
  logic [BYTE_W-1:0]  w_dly_val;
  logic               w_dly_dec;
  logic               w_dly_zero;

`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic            w_timeout;
`endif

  spi_frame_delay u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_val),
    .i_dec      (w_dly_dec),
    .o_zero_c   (w_dly_zero)
  );

  // Received byte appended at the LSB end; earlier bytes move toward the MSB.
  assign w_shift_next = (r_shift << BYTE_W) | FRAME_W'(data_rx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and delay-counter control.
  always_comb begin : p_next
    w_state_next = r_state;
    w_dly_load   = 1'b0;
    w_dly_val    = '0;
    w_dly_dec    = 1'b0;
`ifdef SPI_FRAME_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SETUP;
          w_dly_load   = 1'b1;
          w_dly_val    = SETUP_LD;
        end
      end
      SETUP, GAP: begin
        if (w_dly_zero) begin
          w_state_next = REQ;
        end else begin
          w_dly_dec = 1'b1;
        end
      end
      REQ: begin
        if (shifter_busy) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (!shifter_busy) begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (r_byte_cnt == CNT_W'(NUM_BYTES)) begin
          w_state_next = DONE;
        end else begin
          w_state_next = GAP;
          w_dly_load   = 1'b1;
          w_dly_val    = GAP_LD;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
`ifdef SPI_FRAME_TIMEOUT_EN
    // Watchdog overrides any handshake progress in the same cycle.
    if ((r_state == REQ || r_state == WAIT) &&
        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
      w_timeout    = 1'b1;
      w_state_next = IDLE;
    end
`endif
  end

  // Datapath and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin : p_data
    if (!rst_n) begin
      r_tx        <= '0;
      r_shift     <= '0;
      r_rx_frame  <= '0;
      r_byte_cnt  <= '0;
      r_data_send <= '0;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_get_byte  <= 1'b0;
    end else begin
      r_cs_n     <= !(w_state_next inside {SETUP, REQ, WAIT, CAPTURE, GAP});
      r_busy     <= (w_state_next != IDLE);
      r_done     <= (w_state_next == DONE);
      r_get_byte <= (w_state_next == REQ);
      if (r_state == IDLE && start) begin
        r_tx       <= tx_frame;
        r_shift    <= '0;
        r_byte_cnt <= '0;
      end
      if (w_state_next == REQ && r_state != REQ) begin
        r_data_send <= r_tx[FRAME_W-1 -: BYTE_W];
      end
      if (r_state == REQ && w_state_next == WAIT) begin
        r_tx       <= r_tx << BYTE_W;
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
      if (r_state == CAPTURE) begin
        r_shift <= w_shift_next;
      end
      if (w_state_next == DONE) begin
        r_rx_frame <= w_shift_next;
      end
    end
  end

`ifdef SPI_FRAME_TIMEOUT_EN
  // Watchdog counter restarts on every state entry; error is sticky until next start.
  always_ff @(posedge clk or negedge rst_n) begin : p_timeout
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || !(r_state inside {REQ, WAIT})) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (r_state == IDLE && start) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign cs_n      = r_cs_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign get_byte  = r_get_byte;
  assign data_send = r_data_send;
  assign rx_frame  = r_rx_frame;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

  // Shifter busy lengths per instance.
  localparam int B0 = 3;
  localparam int B1 = 3;
  localparam int B2 = 2;
  localparam int GAP2 = 4;
  // Minimum-latency formula plus B cycles per byte: the bench shifter is
  // registered, costing one extra REQ cycle and B-1 extra WAIT cycles.
  localparam int L0 = 1 + 2 + 5 * (3 + B0) + 4 * 1 + 1;
  localparam int L1 = 1 + 1 + 1 * (3 + B1) + 0 + 1;
  localparam int L2 = 1 + 1 + 2 * (3 + B2) + 1 * GAP2 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters, watchdog limit 16 when built in.
  logic start0 = 1'b0;
  logic [39:0] tx0 = '0;
  logic busy0, done0, cs0, get0, terr0;
  logic [39:0] rx0;
  logic [7:0] ds0;
  logic sh0_busy = 1'b0, sh0_en = 1'b1;
  logic [7:0] sh0_rx = '0;
  int sh0_cnt = 0;

  // Instance 1: single byte, no setup, no gap.
  logic start1 = 1'b0;
  logic [7:0] tx1 = '0;
  logic busy1, done1, cs1, get1, terr1;
  logic [7:0] rx1;
  logic [7:0] ds1;
  logic sh1_busy = 1'b0;
  logic [7:0] sh1_rx = '0;
  int sh1_cnt = 0;

  // Instance 2: two bytes, setup 1, gap 4.
  logic start2 = 1'b0;
  logic [15:0] tx2 = '0;
  logic busy2, done2, cs2, get2, terr2;
  logic [15:0] rx2;
  logic [7:0] ds2;
  logic sh2_busy = 1'b0;
  logic [7:0] sh2_rx = '0;
  int sh2_cnt = 0;

  spi_frame_ctrl #(.NUM_BYTES(5), .CS_SETUP(2), .BYTE_GAP(0), .TIMEOUT_CYCLES(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .tx_frame(tx0), .busy(busy0), .done(done0),
    .rx_frame(rx0), .cs_n(cs0), .get_byte(get0), .data_send(ds0),
    .shifter_busy(sh0_busy), .data_rx(sh0_rx), .timeout_err(terr0));

  spi_frame_ctrl #(.NUM_BYTES(1), .CS_SETUP(0), .BYTE_GAP(0), .TIMEOUT_CYCLES(1024)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_frame(tx1), .busy(busy1), .done(done1),
    .rx_frame(rx1), .cs_n(cs1), .get_byte(get1), .data_send(ds1),
    .shifter_busy(sh1_busy), .data_rx(sh1_rx), .timeout_err(terr1));

  spi_frame_ctrl #(.NUM_BYTES(2), .CS_SETUP(1), .BYTE_GAP(GAP2), .TIMEOUT_CYCLES(1024)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_frame(tx2), .busy(busy2), .done(done2),
    .rx_frame(rx2), .cs_n(cs2), .get_byte(get2), .data_send(ds2),
    .shifter_busy(sh2_busy), .data_rx(sh2_rx), .timeout_err(terr2));

  // Shifter models: busy for B cycles after seeing get_byte, echo data_send ^ FF.
  always @(posedge clk) begin
    if (sh0_cnt != 0) begin
      sh0_cnt <= sh0_cnt - 1;
      if (sh0_cnt == 1) sh0_busy <= 1'b0;
    end else if (get0 && sh0_en) begin
      sh0_busy <= 1'b1; sh0_cnt <= B0; sh0_rx <= ds0 ^ 8'hFF;
    end
    if (sh1_cnt != 0) begin
      sh1_cnt <= sh1_cnt - 1;
      if (sh1_cnt == 1) sh1_busy <= 1'b0;
    end else if (get1) begin
      sh1_busy <= 1'b1; sh1_cnt <= B1; sh1_rx <= ds1 ^ 8'hFF;
    end
    if (sh2_cnt != 0) begin
      sh2_cnt <= sh2_cnt - 1;
      if (sh2_cnt == 1) sh2_busy <= 1'b0;
    end else if (get2) begin
      sh2_busy <= 1'b1; sh2_cnt <= B2; sh2_rx <= ds2 ^ 8'hFF;
    end
  end

  // Monitors: done pulses, get_byte rises, sent bytes, CS drops inside a frame.
  int done_cnt0 = 0, rise0 = 0, cs_bad0 = 0, rise1 = 0, cs_bad2 = 0;
  logic get0_q = 1'b0, get1_q = 1'b0;
  logic [7:0] ds_q[$];
  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (get0 && !get0_q) begin rise0++; ds_q.push_back(ds0); end
    get0_q = get0;
    if (busy0 && !done0 && cs0) cs_bad0++;
    if (get1 && !get1_q) rise1++;
    get1_q = get1;
    if (busy2 && !done2 && cs2) cs_bad2++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic dn(input int which);
    case (which)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  // Runs one frame; lat = cycles from start cycle to done cycle inclusive (-1 on timeout).
  task automatic run_frame(input int which, input logic [39:0] tx, output int lat);
    int cyc;
    case (which)
      0: begin tx0 = tx; start0 = 1'b1; end
      1: begin tx1 = tx[7:0]; start1 = 1'b1; end
      default: begin tx2 = tx[15:0]; start2 = 1'b1; end
    endcase
    tick();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    cyc = 1;
    while (!dn(which) && cyc < 1000) begin tick(); cyc++; end
    lat = dn(which) ? cyc + 1 : -1;
    tick();
  endtask

  typedef struct packed { logic [39:0] tx; logic [39:0] rx; } vec_t;

  initial begin
    vec_t vecs [5];
    int lat, d0, r0, n, g;
    logic [63:0] sent;
    logic [39:0] rx_before;

    vecs[0] = '{tx: 40'h0102030405, rx: 40'hFEFDFCFBFA};
    vecs[1] = '{tx: 40'h0000000000, rx: 40'hFFFFFFFFFF};
    vecs[2] = '{tx: 40'hA55AF00F3C, rx: 40'h5AA50FF0C3};
    vecs[3] = '{tx: 40'hFFFFFFFFFF, rx: 40'h0000000000};
    vecs[4] = '{tx: 40'h8001807F7E, rx: 40'h7FFE7F8081};

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", cs0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_get_byte", get0, 0);
    chk("rst_data_send", ds0, 0);
    chk("rst_rx_frame", rx0, 0);
    chk("rst_timeout_err", terr0, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames on the default instance.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt0;
      ds_q.delete();
      run_frame(0, vecs[i].tx, lat);
      chk($sformatf("vec%0d_rx", i), rx0, vecs[i].rx);
      chk($sformatf("vec%0d_done_pulses", i), done_cnt0 - d0, 1);
      chk($sformatf("vec%0d_nbytes", i), ds_q.size(), 5);
      sent = '0;
      foreach (ds_q[k]) sent = (sent << 8) | 64'(ds_q[k]);
      chk($sformatf("vec%0d_sent", i), sent, 64'(vecs[i].tx));
      chk($sformatf("vec%0d_latency", i), lat, L0);
    end
    chk("u0_cs_low_in_frame", cs_bad0, 0);
    chk("u0_timeout_err_idle", terr0, 0);

    // Single-byte instance: latency and one get_byte.
    r0 = rise1;
    run_frame(1, 40'h3C, lat);
    chk("u1_rx", rx1, 8'hC3);
    chk("u1_latency", lat, L1);
    chk("u1_get_rises", rise1 - r0, 1);
    chk("u1_cs_idle", cs1, 1);

    // Gap instance: cycles from shifter_busy fall to next get_byte.
    tx2 = 16'h1234; start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (!sh2_busy && n < 100) begin tick(); n++; end
    while (sh2_busy && n < 200) begin tick(); n++; end
    g = 0;
    while (!get2 && g < 100) begin tick(); g++; end
    chk("u2_gap_cycles", g, 2 + GAP2);
    n = 0;
    while (!done2 && n < 200) begin tick(); n++; end
    chk("u2_done_seen", done2, 1);
    chk("u2_rx", rx2, 16'hEDCB);
    tick();
    run_frame(2, 40'hFF00, lat);
    chk("u2_rx2", rx2, 16'h00FF);
    chk("u2_latency", lat, L2);
    chk("u2_cs_low_in_frame", cs_bad2, 0);

    // start held high through a frame and its DONE cycle, tx_frame changed mid-frame.
    d0 = done_cnt0;
    tx0 = 40'h1122334455; start0 = 1'b1; tick();
    tx0 = 40'h9988776655;
    n = 0;
    while (!done0 && n < 500) begin tick(); n++; end
    chk("hold_done_seen", done0, 1);
    chk("hold_rx", rx0, 40'hEEDDCCBBAA);
    tx0 = 40'h0F1E2D3C4B;
    tick();
    chk("hold_idle_after_done", busy0, 0);
    chk("hold_one_done", done_cnt0 - d0, 1);
    tick();
    start0 = 1'b0;
    chk("hold_restart_busy", busy0, 1);
    n = 0;
    while (!done0 && n < 500) begin tick(); n++; end
    chk("hold_rx2", rx0, 40'hF0E1D2C3B4);
    tick();

    // Reset during WAIT of byte 3.
    d0 = done_cnt0; r0 = rise0;
    tx0 = 40'hCAFEBABE01; start0 = 1'b1; tick(); start0 = 1'b0;
    n = 0;
    while (!((rise0 - r0) == 3 && !get0 && sh0_busy) && n < 500) begin tick(); n++; end
    chk("rstmid_reached_wait", n < 500, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", cs0, 1);
    chk("rstmid_busy", busy0, 0);
    chk("rstmid_rx", rx0, 0);
    chk("rstmid_get", get0, 0);
    repeat (3) tick();
    chk("rstmid_no_done", done_cnt0 - d0, 0);
    rst_n = 1'b1;
    repeat (B0 + 3) tick();
    run_frame(0, 40'h0102030405, lat);
    chk("rstmid_next_rx", rx0, 40'hFEFDFCFBFA);
    chk("rstmid_next_latency", lat, L0);

`ifdef SPI_FRAME_TIMEOUT_EN
    // Shifter never answers: watchdog ends the frame after 16 REQ cycles.
    rx_before = rx0; d0 = done_cnt0; sh0_en = 1'b0;
    tx0 = 40'h1111111111; start0 = 1'b1; tick(); start0 = 1'b0;
    n = 0; g = 0;
    while (busy0 && n < 300) begin if (get0) g++; tick(); n++; end
    chk("to_req_cycles", g, 16);
    chk("to_err", terr0, 1);
    chk("to_cs_n", cs0, 1);
    chk("to_get", get0, 0);
    chk("to_no_done", done_cnt0 - d0, 0);
    chk("to_rx_kept", rx0, rx_before);
    repeat (2) tick();
    chk("to_err_sticky", terr0, 1);
    sh0_en = 1'b1;
    tx0 = 40'h5A5A5A5A5A; start0 = 1'b1; tick(); start0 = 1'b0;
    chk("to_err_cleared", terr0, 0);
    n = 0;
    while (!done0 && n < 500) begin tick(); n++; end
    chk("to_next_rx", rx0, 40'hA5A5A5A5A5);
    tick();
`else
    // Shifter stalls: REQ must hold indefinitely, then the frame completes.
    sh0_en = 1'b0;
    tx0 = 40'h1111111111; start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (40) tick();
    chk("stall_get_held", get0, 1);
    chk("stall_cs_low", cs0, 0);
    chk("stall_busy", busy0, 1);
    chk("stall_no_timeout", terr0, 0);
    sh0_en = 1'b1;
    n = 0;
    while (!done0 && n < 500) begin tick(); n++; end
    chk("stall_done_seen", done0, 1);
    chk("stall_rx", rx0, 40'hEEEEEEEEEE);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
